// File: rtl/fp_add_align.sv
// fp_add_align: two-stage pre-adder for the binary32 FP adder.
// Stage 1 unpacks both operands, puts the larger magnitude in A, and decodes
// NaN/Inf. Stage 2 right-aligns B into a 28-bit slot with guard/round/sticky
// and pre-encodes subtraction as ~B + 1 for the downstream 28-bit CLA.
// Optional build macro: FP_ADD_ALIGN_SUBNORMAL_EN (subnormals kept with
// effective exponent 1); without it subnormals flush to signed zero.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_valid / o_ready     upstream handshake, i_op_a, i_op_b, i_sub operands
//   o_valid / i_ready     downstream handshake
//   o_data_a, o_data_b    28-bit adder operands, o_carry adder carry-in
//   o_exp, o_sign         larger exponent, pre-normalisation sign
//   o_eff_sub             effective subtraction
//   o_special, o_special_result  NaN/Inf bypass result
module fp_add_align (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_op_a,
  input  logic [31:0] i_op_b,
  input  logic        i_sub,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [27:0] o_data_a,
  output logic [27:0] o_data_b,
  output logic        o_carry,
  output logic [7:0]  o_exp,
  output logic        o_sign,
  output logic        o_eff_sub,
  output logic        o_special,
  output logic [31:0] o_special_result
);

  typedef struct packed {
    logic [23:0] sig_a;   // {hidden, fraction}
    logic [23:0] sig_b;
    logic [7:0]  exp;
    logic [7:0]  diff;
    logic        eff_sub;
    logic        sign;
    logic        special;
    logic [31:0] special_result;
  } s1_t;

  typedef struct packed {
    logic [27:0] data_a;
    logic [27:0] data_b;
    logic        carry;
    logic [7:0]  exp;
    logic        sign;
    logic        eff_sub;
    logic        special;
    logic [31:0] special_result;
  } s2_t;

  // vld_pipe_q[0] = stage 1 valid, vld_pipe_q[1] = stage 2 valid
  logic [1:0] vld_pipe_q, vld_pipe_d;
  s1_t        s1_q, s1_d, s1_new;
  s2_t        s2_q, s2_d, s2_new;
  logic       en1, en2;

  // ---------------- stage 1: unpack / compare ----------------
  logic [7:0]  exp_a, exp_b, eexp_a, eexp_b;
  logic [22:0] frac_a, frac_b;
  logic        sign_b, eff_sub, swap, mag_eq;
  logic        nan_a, nan_b, inf_a, inf_b;

  always_comb begin
    exp_a  = i_op_a[30:23];
    exp_b  = i_op_b[30:23];
`ifdef FP_ADD_ALIGN_SUBNORMAL_EN
    frac_a = i_op_a[22:0];
    frac_b = i_op_b[22:0];
    eexp_a = (exp_a == 8'd0 && frac_a != 23'd0) ? 8'd1 : exp_a;
    eexp_b = (exp_b == 8'd0 && frac_b != 23'd0) ? 8'd1 : exp_b;
`else
    frac_a = (exp_a == 8'd0) ? 23'd0 : i_op_a[22:0];
    frac_b = (exp_b == 8'd0) ? 23'd0 : i_op_b[22:0];
    eexp_a = exp_a;
    eexp_b = exp_b;
`endif
    sign_b  = i_op_b[31] ^ i_sub;
    eff_sub = i_op_a[31] ^ sign_b;
    // Tie keeps a as A so equal magnitudes never swap.
    swap    = {exp_b, frac_b} > {exp_a, frac_a};
    mag_eq  = {exp_b, frac_b} == {exp_a, frac_a};
    nan_a   = (exp_a == 8'hFF) && (i_op_a[22:0] != 23'd0);
    nan_b   = (exp_b == 8'hFF) && (i_op_b[22:0] != 23'd0);
    inf_a   = (exp_a == 8'hFF) && (i_op_a[22:0] == 23'd0);
    inf_b   = (exp_b == 8'hFF) && (i_op_b[22:0] == 23'd0);

    s1_new = '0;
    s1_new.sig_a   = swap ? {exp_b != 8'd0, frac_b} : {exp_a != 8'd0, frac_a};
    s1_new.sig_b   = swap ? {exp_a != 8'd0, frac_a} : {exp_b != 8'd0, frac_b};
    s1_new.exp     = swap ? eexp_b : eexp_a;
    s1_new.diff    = swap ? (eexp_b - eexp_a) : (eexp_a - eexp_b);
    s1_new.eff_sub = eff_sub;
    // x - x is +0 in round-to-nearest.
    s1_new.sign    = (eff_sub && mag_eq) ? 1'b0 : (swap ? sign_b : i_op_a[31]);
    if (nan_a || nan_b || (inf_a && inf_b && eff_sub)) begin
      s1_new.special        = 1'b1;
      s1_new.special_result = 32'h7FC0_0000;
    end else if (inf_a) begin
      s1_new.special        = 1'b1;
      s1_new.special_result = {i_op_a[31], 31'h7F80_0000};
    end else if (inf_b) begin
      s1_new.special        = 1'b1;
      s1_new.special_result = {sign_b, 31'h7F80_0000};
    end
  end

  // ---------------- stage 2: align / encode ----------------
  logic [27:0] b_full, b_aln, lost_mask;
  logic [4:0]  shamt;

  always_comb begin
    b_full    = {1'b0, s1_q.sig_b, 3'b000};
    shamt     = s1_q.diff[4:0];
    lost_mask = ~({28{1'b1}} << shamt);
    if (s1_q.diff >= 8'd27)
      b_aln = {27'd0, |b_full};
    else
      b_aln = (b_full >> shamt) | {27'd0, |(b_full & lost_mask)};

    s2_new                = '0;
    s2_new.data_a         = {1'b0, s1_q.sig_a, 3'b000};
    s2_new.data_b         = s1_q.eff_sub ? ~b_aln : b_aln;
    s2_new.carry          = s1_q.eff_sub;
    s2_new.exp            = s1_q.exp;
    s2_new.sign           = s1_q.sign;
    s2_new.eff_sub        = s1_q.eff_sub;
    s2_new.special        = s1_q.special;
    s2_new.special_result = s1_q.special_result;
  end

  // ---------------- handshake ----------------
  // o_ready is combinational on i_ready: no skid buffer.
  always_comb begin
    en2        = ~vld_pipe_q[1] | i_ready;
    en1        = ~vld_pipe_q[0] | en2;
    vld_pipe_d = vld_pipe_q;
    s1_d       = s1_q;
    s2_d       = s2_q;
    if (en1) begin
      vld_pipe_d[0] = i_valid;
      s1_d          = s1_new;
    end
    if (en2) begin
      vld_pipe_d[1] = vld_pipe_q[0];
      s2_d          = s2_new;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_pipe_q <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
    end
  end

  assign o_ready          = en1;
  assign o_valid          = vld_pipe_q[1];
  assign o_data_a         = s2_q.data_a;
  assign o_data_b         = s2_q.data_b;
  assign o_carry          = s2_q.carry;
  assign o_exp            = s2_q.exp;
  assign o_sign           = s2_q.sign;
  assign o_eff_sub        = s2_q.eff_sub;
  assign o_special        = s2_q.special;
  assign o_special_result = s2_q.special_result;

endmodule

// File: tb/tb_fp_add_align.sv
// Directed testbench for fp_add_align.
module tb_fp_add_align;
  logic        i_clk = 1'b0;
  logic        i_rst, i_valid, o_ready, i_sub, o_valid, i_ready;
  logic [31:0] i_op_a, i_op_b, o_special_result;
  logic [27:0] o_data_a, o_data_b;
  logic        o_carry, o_sign, o_eff_sub, o_special;
  logic [7:0]  o_exp;
  int          tests = 0;
  int          fails = 0;

  fp_add_align dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_op_a(i_op_a), .i_op_b(i_op_b), .i_sub(i_sub), .o_valid(o_valid),
    .i_ready(i_ready), .o_data_a(o_data_a), .o_data_b(o_data_b),
    .o_carry(o_carry), .o_exp(o_exp), .o_sign(o_sign), .o_eff_sub(o_eff_sub),
    .o_special(o_special), .o_special_result(o_special_result)
  );

  always #5 i_clk = ~i_clk;

  // Drive one pair for one cycle, then wait (bounded) for o_valid.
  // n returns the number of edges after the accept edge until o_valid.
  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic sub, output int n);
    @(posedge i_clk); #1;
    i_ready = 1'b1; i_op_a = a; i_op_b = b; i_sub = sub; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    n = 0;
    while (!o_valid && n < 10) begin
      @(posedge i_clk); #1;
      n++;
    end
    if (!o_valid) begin
      tests++; fails++;
      $display("FAIL timeout waiting o_valid a=%h b=%h", a, b);
    end
  endtask

  task automatic test_reset;
    i_rst = 1'b1; i_valid = 1'b1; i_ready = 1'b1; i_sub = 1'b0;
    i_op_a = 32'h3F80_0000; i_op_b = 32'h3F80_0000;
    repeat (2) @(posedge i_clk);
    #1;
    tests++;
    if ({o_valid, o_data_a, o_data_b, o_carry, o_exp, o_sign, o_eff_sub, o_special, o_special_result} !== '0) begin
      fails++; $display("FAIL reset_outputs got v=%b a=%h b=%h exp=%h", o_valid, o_data_a, o_data_b, o_exp);
    end
    i_rst = 1'b0; i_valid = 1'b0;
    tests++;
    if (o_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", o_ready); end
  endtask

  task automatic test_add_same;
    int n;
    send(32'h3F80_0000, 32'h3F80_0000, 1'b0, n);
    tests++; if (n !== 1) begin fails++; $display("FAIL latency got %0d exp 1", n); end
    tests++; if (o_data_a !== 28'h400_0000) begin fails++; $display("FAIL add_same data_a got %h exp 4000000", o_data_a); end
    tests++; if (o_data_b !== 28'h400_0000) begin fails++; $display("FAIL add_same data_b got %h exp 4000000", o_data_b); end
    tests++; if ({o_carry, o_sign, o_special, o_eff_sub} !== 4'b0000) begin fails++; $display("FAIL add_same flags got %b exp 0000", {o_carry, o_sign, o_special, o_eff_sub}); end
    tests++; if (o_exp !== 8'h7F) begin fails++; $display("FAIL add_same exp got %h exp 7f", o_exp); end
  endtask

  task automatic test_sub;
    int n;
    logic [27:0] sum;
    send(32'h3F80_0000, 32'h3F00_0000, 1'b1, n);
    sum = o_data_a + o_data_b + {27'd0, o_carry};
    tests++; if (o_data_a !== 28'h400_0000) begin fails++; $display("FAIL sub data_a got %h exp 4000000", o_data_a); end
    tests++; if (o_data_b !== 28'hDFF_FFFF) begin fails++; $display("FAIL sub data_b got %h exp dffffff", o_data_b); end
    tests++; if ({o_carry, o_eff_sub, o_sign} !== 3'b110) begin fails++; $display("FAIL sub flags got %b exp 110", {o_carry, o_eff_sub, o_sign}); end
    tests++; if (sum !== 28'h200_0000) begin fails++; $display("FAIL sub sum got %h exp 2000000", sum); end
    // swapped: 0.5 - 1.0, A = 1.0 carrying the negated b sign
    send(32'h3F00_0000, 32'h3F80_0000, 1'b1, n);
    tests++; if ({o_data_a, o_data_b} !== {28'h400_0000, 28'hDFF_FFFF}) begin fails++; $display("FAIL swap data got %h %h exp 4000000 dffffff", o_data_a, o_data_b); end
    tests++; if ({o_sign, o_eff_sub, o_exp} !== {2'b11, 8'h7F}) begin fails++; $display("FAIL swap sign/exp got %b %h exp 1 7f", o_sign, o_exp); end
    // -1 - -1: equal magnitudes under subtraction give +0 sign
    send(32'hBF80_0000, 32'hBF80_0000, 1'b1, n);
    tests++; if ({o_sign, o_eff_sub, o_data_b} !== {2'b01, 28'hBFF_FFFF}) begin fails++; $display("FAIL eq_sub got sign=%b eff=%b b=%h exp 0 1 bffffff", o_sign, o_eff_sub, o_data_b); end
  endtask

  task automatic test_sticky;
    int n;
    send(32'h3F80_0000, 32'h3080_0000, 1'b0, n);   // d = 30
    tests++; if (o_data_b !== 28'h000_0001) begin fails++; $display("FAIL sticky_far got %h exp 0000001", o_data_b); end
    tests++; if (o_exp !== 8'h7F) begin fails++; $display("FAIL sticky_far exp got %h exp 7f", o_exp); end
    send(32'h3F80_0000, 32'h3D80_0001, 1'b0, n);   // d = 4, lost bits 1000
    tests++; if (o_data_b !== 28'h040_0001) begin fails++; $display("FAIL sticky_d4 got %h exp 0400001", o_data_b); end
    send(32'h3F80_0000, 32'h3E00_0001, 1'b0, n);   // d = 3, lost bits 000
    tests++; if (o_data_b !== 28'h080_0001) begin fails++; $display("FAIL shift_d3 got %h exp 0800001", o_data_b); end
  endtask

  task automatic test_special;
    int n;
    send(32'h7F80_0000, 32'h7F80_0000, 1'b1, n);
    tests++; if ({o_special, o_special_result} !== {1'b1, 32'h7FC0_0000}) begin fails++; $display("FAIL inf_minus_inf got %b %h exp 1 7fc00000", o_special, o_special_result); end
    send(32'hFF80_0000, 32'h3F80_0000, 1'b0, n);
    tests++; if ({o_special, o_special_result} !== {1'b1, 32'hFF80_0000}) begin fails++; $display("FAIL neg_inf got %b %h exp 1 ff800000", o_special, o_special_result); end
    send(32'h3F80_0000, 32'h7FC0_0001, 1'b0, n);
    tests++; if ({o_special, o_special_result} !== {1'b1, 32'h7FC0_0000}) begin fails++; $display("FAIL nan got %b %h exp 1 7fc00000", o_special, o_special_result); end
    send(32'h3F80_0000, 32'h7F80_0000, 1'b1, n);
    tests++; if ({o_special, o_special_result} !== {1'b1, 32'hFF80_0000}) begin fails++; $display("FAIL one_minus_inf got %b %h exp 1 ff800000", o_special, o_special_result); end
  endtask

  task automatic test_subnormal;
    int n;
`ifdef FP_ADD_ALIGN_SUBNORMAL_EN
    send(32'h0000_0001, 32'h0000_0001, 1'b0, n);
    tests++; if ({o_data_a, o_data_b} !== {28'h000_0008, 28'h000_0008}) begin fails++; $display("FAIL subn data got %h %h exp 0000008 0000008", o_data_a, o_data_b); end
    tests++; if (o_exp !== 8'h01) begin fails++; $display("FAIL subn exp got %h exp 01", o_exp); end
`else
    send(32'h0000_0001, 32'h3F80_0000, 1'b0, n);
    tests++; if ({o_data_a, o_data_b, o_exp} !== {28'h400_0000, 28'h0, 8'h7F}) begin fails++; $display("FAIL flush got %h %h %h exp 4000000 0000000 7f", o_data_a, o_data_b, o_exp); end
    send(32'h8000_0001, 32'h0000_0001, 1'b0, n);
    tests++; if ({o_data_a, o_data_b, o_exp, o_sign, o_eff_sub} !== {28'h0, 28'hFFF_FFFF, 8'h00, 2'b01}) begin fails++; $display("FAIL flush_zero got %h %h %h %b %b", o_data_a, o_data_b, o_exp, o_sign, o_eff_sub); end
`endif
  endtask

  // Four back-to-back pairs; i_ready dropped for 3 cycles at first o_valid.
  task automatic test_backpressure;
    logic [31:0] op_a [4];
    logic [7:0]  exp_e [4];
    logic [27:0] db_e [4];
    logic [63:0] held;
    bit          have_held, seen;
    int          sent, recv, stall;
    op_a  = '{32'h3F80_0000, 32'h4000_0000, 32'h4080_0000, 32'h4100_0000};
    exp_e = '{8'h7F, 8'h80, 8'h81, 8'h82};
    db_e  = '{28'h400_0000, 28'h200_0000, 28'h100_0000, 28'h080_0000};
    sent = 0; recv = 0; stall = 0; seen = 0; have_held = 0; held = '0;
    repeat (3) @(posedge i_clk);
    for (int cyc = 0; cyc < 30 && recv < 4; cyc++) begin
      @(posedge i_clk); #1;
      if (o_valid && !seen) begin seen = 1; stall = 3; end
      i_ready = (stall == 0);
      i_valid = (sent < 4);
      i_op_a  = op_a[sent % 4]; i_op_b = 32'h3F80_0000; i_sub = 1'b0;
      #1;
      if (!i_ready && o_valid) begin
        tests++; if (o_ready !== 1'b0) begin fails++; $display("FAIL bp_ready got %b exp 0", o_ready); end
        if (have_held) begin
          tests++; if ({o_data_b, o_exp, o_data_a} !== held) begin fails++; $display("FAIL bp_stable got %h exp %h", {o_data_b, o_exp, o_data_a}, held); end
        end
        held = {o_data_b, o_exp, o_data_a}; have_held = 1;
      end
      if (i_valid && o_ready) sent++;
      if (o_valid && i_ready) begin
        tests++; if ({o_exp, o_data_b} !== {exp_e[recv], db_e[recv]}) begin fails++; $display("FAIL bp_order[%0d] got %h %h exp %h %h", recv, o_exp, o_data_b, exp_e[recv], db_e[recv]); end
        recv++;
      end
      if (stall > 0) stall--;
    end
    i_valid = 1'b0; i_ready = 1'b1;
    tests++; if (recv !== 4) begin fails++; $display("FAIL bp_count got %0d exp 4", recv); end
  endtask

  task automatic test_reset_midflight;
    @(posedge i_clk); #1;
    i_ready = 1'b0; i_valid = 1'b1; i_sub = 1'b0;
    i_op_a = 32'h3F80_0000; i_op_b = 32'h3F80_0000;
    @(posedge i_clk); #1;
    i_op_a = 32'h4000_0000;
    @(posedge i_clk); #1;
    tests++; if ({o_valid, o_ready} !== 2'b10) begin fails++; $display("FAIL mid_full got v=%b r=%b exp 1 0", o_valid, o_ready); end
    i_rst = 1'b1;   // i_valid left high: must be ignored under reset
    @(posedge i_clk); #1;
    i_rst = 1'b0; i_valid = 1'b0;
    tests++;
    if ({o_valid, o_data_a, o_data_b, o_exp, o_carry, o_special, o_eff_sub} !== '0) begin
      fails++; $display("FAIL mid_reset got v=%b a=%h b=%h exp=%h", o_valid, o_data_a, o_data_b, o_exp);
    end
    tests++; if (o_ready !== 1'b1) begin fails++; $display("FAIL mid_reset_ready got %b exp 1", o_ready); end
    i_ready = 1'b1;
    repeat (3) begin
      @(posedge i_clk); #1;
      tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL mid_stale got o_valid=%b exp 0", o_valid); end
    end
  endtask

  initial begin
    test_reset;
    test_add_same;
    test_sub;
    test_sticky;
    test_special;
    test_subnormal;
    test_backpressure;
    test_reset_midflight;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fp_add_align.md
# fp_add_align

Two-stage pipelined pre-adder stage of the single-precision FP adder. Unpacks two IEEE-754 binary32 operands, orders them by magnitude, right-aligns the smaller significand with guard/round/sticky and presents two 28-bit operands plus carry-in directly to the 28-bit carry-lookahead adder. Subtraction is pre-encoded (inverted B, carry-in 1), so the adder always computes |A| − |B| ≥ 0. NaN/Inf cases bypass the datapath with a ready-made result.

## Interface
- No parameters; widths fixed by binary32 and the 28-bit adder.
- i_clk  input  1  clock, all state on rising edge
- i_rst  input  1  synchronous, active-high reset
- i_valid  input  1  upstream operand pair valid
- o_ready  output  1  stage can accept this cycle
- i_op_a, i_op_b  input  32  binary32 operands
- i_sub  input  1  1 = a − b, 0 = a + b
- o_valid  output  1  outputs valid
- i_ready  input  1  downstream accepts this cycle
- o_data_a  output  28  larger significand: bit27 = 0, bit26 hidden, [25:3] fraction, [2:0] = 000
- o_data_b  output  28  aligned smaller significand (bitwise inverted when o_eff_sub)
- o_carry  output  1  adder carry-in; equals o_eff_sub
- o_exp  output  8  larger operand's biased exponent
- o_sign  output  1  result sign before normalisation
- o_eff_sub  output  1  effective subtraction
- o_special  output  1  o_special_result is final; adder result ignored
- o_special_result  output  32  NaN/Inf result

## Operation
- Stage 1 (unpack/compare): effective sign of b = b[31] ^ i_sub; eff_sub = a[31] ^ effective b sign. Magnitude compare on {exp, fraction}; larger becomes A. Tie keeps a as A. Register A/B fields, exp diff d = expA − expB (8-bit, non-negative), eff_sub, sign, special decode.
- Stage 2 (align/encode): B significand {0, hidden, frac, 000} shifted right by d; bits shifted out OR-reduced into bit 0 (sticky). d ≥ 27 → B = 27'b0 with bit0 = (B significand ≠ 0). If eff_sub, o_data_b = ~B_aligned (28-bit), o_carry = 1; else o_data_b = B_aligned, o_carry = 0.
- Sign: o_sign = A sign (a[31], or effective b sign if swapped); if eff_sub and magnitudes equal, o_sign = 0.
- Zero (exp 0, frac 0): hidden bit 0.
- Specials (exp 255): any NaN, or Inf with Inf under eff_sub → o_special = 1, o_special_result = 0x7FC00000. Else one/both Inf → signed Inf (0x7F800000 | sign<<31). Datapath outputs still driven, don't-care.
- Handshake: en2 = ~v2 | i_ready; en1 = ~v1 | en2; o_ready = en1. Input accepted when i_valid & o_ready. Each stage register loads only when its enable is high; v1 loads i_valid & o_ready, v2 loads v1. No drop, no duplication, order preserved.

## Timing
- Latency 2 cycles accept-to-o_valid; throughput 1/cycle with i_ready held high.
- i_ready low: outputs held bit-stable while o_valid = 1; stage 1 fills, then o_ready falls combinationally in the cycle both stages are full.
- o_ready depends combinationally on i_ready (no skid buffer); documented, accepted.
- Reset: v1, v2, o_valid = 0; all data outputs, o_special, o_carry, o_eff_sub = 0; o_ready = 1 in the cycle after reset deasserts. Reset mid-operation discards all in-flight pairs; i_valid ignored during reset.
- Simultaneous accept and output drain in one cycle is permitted and required for full throughput.

## Configuration
- FP_ADD_ALIGN_SUBNORMAL_EN defined: exp 0 with frac ≠ 0 is subnormal — hidden bit 0, effective exponent 1 for d and o_exp.
- Undefined: subnormal inputs flushed to signed zero before compare (fraction forced 0); o_exp = 0 for such an A.

## Test plan
- 0x3F800000 + 0x3F800000, i_sub=0 → 2 cycles later o_data_a = o_data_b = 0x4000000, o_carry = 0, o_exp = 0x7F, o_sign = 0, o_special = 0.
- 0x3F800000 − 0x3F000000 → o_data_a = 0x4000000, o_data_b = 0xDFFFFFF, o_carry = 1, o_eff_sub = 1; adder sum 0x2000000.
- 0x3F800000 + 0x30800000 (d = 30) → o_data_b = 0x0000001 (sticky only), o_exp = 0x7F.
- 0x7F800000 − 0x7F800000 → o_special = 1, result 0x7FC00000; 0xFF800000 + 0x3F800000 → 0xFF800000.
- Backpressure: 4 back-to-back pairs, i_ready = 0 for 3 cycles after first o_valid → o_ready = 0 once 2 held, outputs stable, all 4 delivered in order.
- i_rst pulsed with both stages valid → next cycle o_valid = 0, all outputs 0, o_ready = 1; macro-on run: 0x00000001 + 0x00000001 → o_data_a = o_data_b = 0x0000008, o_exp = 1.
